pipelined_ripple_adder: RTL and testbench

PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

---
 rtl/pipelined_ripple_adder.sv | 91 +++++++++
 tb/tb_pipelined_ripple_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: STAGES slices of WIDTH/STAGES bits, one slice per stage, valid/ready flow control.
// Define PIPELINED_RIPPLE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             co
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    // WIDTH must be a multiple of STAGES
    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [SW:0]       w_slc [STAGES];
    logic [WIDTH-1:0]  w_anx [STAGES];
    logic              w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage k adds slice k; r_a carries finished sum slices below k and raw A slices above k
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_slc[k] = (SW+1)'(r_a[k][k*SW +: SW]) + (SW+1)'(r_b[k][k*SW +: SW]) + (SW+1)'(r_c[k]);
            w_anx[k] = r_a[k];
            w_anx[k][k*SW +: SW] = w_slc[k][SW-1:0];
        end
    end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic w_cmsb;

    // Carry into the MSB recovered from the MSB sum bit and its operands
    assign w_cmsb = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ w_anx[LAST][WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v       <= '0;
            r_c       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            out_valid <= 1'b0;
            SUM       <= '0;
            co        <= 1'b0;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            r_a[0] <= A;
            r_b[0] <= B;
            r_c[0] <= ci;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k] <= r_v[k-1];
                r_a[k] <= w_anx[k-1];
                r_b[k] <= r_b[k-1];
                r_c[k] <= w_slc[k-1][SW];
            end
            out_valid <= r_v[LAST];
            // Bubbles leave the last result in place
            if (r_v[LAST]) begin
                SUM <= w_anx[LAST];
                co  <= w_slc[LAST][SW];
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
                ovf <= w_cmsb ^ w_slc[LAST][SW];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=16, STAGES=4) against a cycle-level reference model.
module tb_pipelined_ripple_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             co;
    logic             tb_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model: a STAGES-deep delay line of precomputed results plus the output slot
    logic        m_v [STAGES];
    logic [17:0] m_d [STAGES];
    logic        m_ov;
    logic [17:0] m_res;
    int          acc;
    int          cons;

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic ovf;
    assign tb_ovf = ovf;
`else
    assign tb_ovf = 1'b0;
`endif

    pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .co        (co)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // {ovf, co, sum} from plain integer arithmetic
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        int  u;
        int  s;
        logic ov;
        u  = int'(a) + int'(b) + int'(c);
        s  = int'($signed(a)) + int'($signed(b)) + int'(c);
        ov = (s > 32767) || (s < -32768);
        return {ov, u[16:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < STAGES; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_ov  = 1'b0;
        m_res = '0;
        acc   = 0;
        cons  = 0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] s, input logic c, input logic o);
        chk(tag, 32'({out_valid, co, tb_ovf, SUM}), 32'({v, c, o & HAS_OVF, s}));
    endtask

    // One clock: check outputs, drive inputs, advance model, wait for the next falling edge
    task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic c, input logic ordy);
        logic adv;
        chk("outputs", 32'({out_valid, co, tb_ovf, SUM}),
            32'({m_ov, m_res[16], m_res[17] & HAS_OVF, m_res[15:0]}));
        in_valid  = iv;
        A         = a;
        B         = b;
        ci        = c;
        out_ready = ordy;
        #1;
        adv = !m_ov || ordy;
        chk("in_ready", 32'(in_ready), 32'(adv));
        if (out_valid && out_ready) cons++;
        if (adv) begin
            m_ov = m_v[STAGES-1];
            if (m_v[STAGES-1]) m_res = m_d[STAGES-1];
            for (int i = STAGES - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_d[i] = m_d[i-1];
            end
            m_v[0] = iv;
            m_d[0] = ref_add(a, b, c);
            if (iv) acc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_outputs", 32'({out_valid, co, tb_ovf, SUM}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        ci        = 1'b0;
        out_ready = 1'b0;
        #1;
        do_reset();

        // Single beat, exact latency
        cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("lat_early", 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("single", 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-to-back beats
        cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
        cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 16'h00F0, 16'h0F0F, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("b2b_0", 1'b1, 16'h0003, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("b2b_1", 1'b1, 16'h8000, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("b2b_2", 1'b1, 16'h1000, 1'b0, 1'b0);

        // Bubble in the middle: out_valid 1,0,1 with SUM retained
        cyc(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("bub_0", 1'b1, 16'h0030, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("bub_1", 1'b0, 16'h0030, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("bub_2", 1'b1, 16'h0102, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Back-pressure on a full pipeline
        acc  = 0;
        cons = 0;
        repeat (6) cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        repeat (3) cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (8) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("stall_count", 32'(cons), 32'(acc));

        // Reset with beats in flight, then accept on the first edge after release
        repeat (3) cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        do_reset();
        cyc(1'b1, 16'h0005, 16'h0006, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("post_rst_gap", 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        expect_out("post_rst", 1'b1, 16'h000B, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Random traffic with random back-pressure
        acc    = 0;
        cons   = 0;
        budget = 40000;
        while (acc < 10000 && budget > 0) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                $urandom_range(0, 3) != 0);
            budget--;
        end
        chk("rand_budget", 32'(acc >= 10000), 32'd1);
        repeat (8) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("rand_count", 32'(cons), 32'(acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
